operand_issue_stage: RTL

Issue stage between decode and the execution units (ALU/MUL/dTLB). It holds one decoded instruction in an issue slot and drives its source registers to the hazard/bypass unit. It selects each operand from the bypass data or the register-file read data, and stalls while any source is blocked. Resolved instructions are launched into a registered output toward execute, with valid/ready handshakes on both sides and flush support.

---
 rtl/operand_issue_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/operand_issue_stage.sv
// operand_issue_stage
//
// Issue stage sitting between decode and the execution units. One decoded
// instruction is parked in the issue slot. Its source indices go out to the
// hazard/bypass unit and to the register-file read ports. Each operand is
// taken from the bypass network when it hits and from the register file
// otherwise. The instruction waits in the slot while any enabled source is
// blocked. Resolved instructions launch into a registered output toward
// execute. Both sides use valid/ready handshakes, and a flush kills the slot
// and the output register.
//
// Occupancy (slot_valid | ex_valid | meaning):
//   0 | 0 | idle, decode accepted freely
//   1 | 0 | instruction waiting on operands (or about to launch)
//   0 | 1 | launched instruction waiting for execute
//   1 | 1 | pipeline full, slot launches only when execute drains
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               kill slot and output register on the next edge
//   dec_*               decode-side instruction and valid/ready handshake
//   enable1/2, regIdx1/2   slot sources to the hazard unit and register file
//   block1/2            source pending with no bypass available
//   hitBypass1/2, bypassData1/2   bypass network
//   rf_rdata1/2         combinational register-file read data at regIdx1/2
//   ex_*                registered launch toward execute, with ex_ready
//   stall_cnt           saturating count of cycles lost to operand hazards

module operand_issue_stage #(
    parameter int ARCH_BITS    = 32,
    parameter int REG_IDX_BITS = 5,
    parameter int OP_BITS      = 6,
    parameter int CNT_BITS     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,

    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [ARCH_BITS-1:0]    dec_pc,
    input  logic [OP_BITS-1:0]      dec_op,
    input  logic [REG_IDX_BITS-1:0] dec_dst,
    input  logic                    dec_we,
    input  logic                    dec_src1_en,
    input  logic                    dec_src2_en,
    input  logic [REG_IDX_BITS-1:0] dec_src1,
    input  logic [REG_IDX_BITS-1:0] dec_src2,
    input  logic                    dec_use_imm,
    input  logic [ARCH_BITS-1:0]    dec_imm,

    output logic                    enable1,
    output logic                    enable2,
    output logic [REG_IDX_BITS-1:0] regIdx1,
    output logic [REG_IDX_BITS-1:0] regIdx2,
    input  logic                    block1,
    input  logic                    block2,
    input  logic                    hitBypass1,
    input  logic                    hitBypass2,
    input  logic [ARCH_BITS-1:0]    bypassData1,
    input  logic [ARCH_BITS-1:0]    bypassData2,
    input  logic [ARCH_BITS-1:0]    rf_rdata1,
    input  logic [ARCH_BITS-1:0]    rf_rdata2,

    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [ARCH_BITS-1:0]    ex_pc,
    output logic [OP_BITS-1:0]      ex_op,
    output logic [REG_IDX_BITS-1:0] ex_dst,
    output logic                    ex_we,
    output logic [ARCH_BITS-1:0]    ex_opA,
    output logic [ARCH_BITS-1:0]    ex_opB,
    output logic [ARCH_BITS-1:0]    ex_src2_data,

    output logic [CNT_BITS-1:0]     stall_cnt
);

    // Issue slot contents
    logic                    slot_valid;
    logic [ARCH_BITS-1:0]    slot_pc;
    logic [OP_BITS-1:0]      slot_op;
    logic [REG_IDX_BITS-1:0] slot_dst;
    logic                    slot_we;
    logic                    slot_src1_en;
    logic                    slot_src2_en;
    logic [REG_IDX_BITS-1:0] slot_src1;
    logic [REG_IDX_BITS-1:0] slot_src2;
    logic                    slot_use_imm;
    logic [ARCH_BITS-1:0]    slot_imm;

    logic [ARCH_BITS-1:0]    res1;
    logic [ARCH_BITS-1:0]    res2;
    logic [ARCH_BITS-1:0]    res_opb;
    logic                    ready_src;
    logic                    out_free;
    logic                    issue;
    logic                    accept;
    logic                    stall_cycle;

    assign enable1 = slot_valid & slot_src1_en;
    assign enable2 = slot_valid & slot_src2_en;
    assign regIdx1 = slot_src1;
    assign regIdx2 = slot_src2;

    // Bypass takes priority over the register file regardless of block.
    assign res1    = hitBypass1 ? bypassData1 : rf_rdata1;
    assign res2    = hitBypass2 ? bypassData2 : rf_rdata2;
    assign res_opb = slot_use_imm ? slot_imm : res2;

    assign ready_src = !(enable1 & block1) & !(enable2 & block2);
    assign out_free  = !ex_valid | ex_ready;
    assign issue     = slot_valid & ready_src & out_free & !flush;

    // Accept into an empty slot, or into one that is launching this cycle.
    // Combinational through block1/2, so decode sees hazards the same cycle.
    assign dec_ready = (!slot_valid | issue) & !flush;
    assign accept    = dec_valid & dec_ready;

    // Only operand hazards are counted; output back-pressure is not.
    assign stall_cycle = slot_valid & !ready_src & !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid   <= 1'b0;
            slot_pc      <= '0;
            slot_op      <= '0;
            slot_dst     <= '0;
            slot_we      <= 1'b0;
            slot_src1_en <= 1'b0;
            slot_src2_en <= 1'b0;
            slot_src1    <= '0;
            slot_src2    <= '0;
            slot_use_imm <= 1'b0;
            slot_imm     <= '0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (accept) begin
            slot_valid   <= 1'b1;
            slot_pc      <= dec_pc;
            slot_op      <= dec_op;
            slot_dst     <= dec_dst;
            slot_we      <= dec_we;
            slot_src1_en <= dec_src1_en;
            slot_src2_en <= dec_src2_en;
            slot_src1    <= dec_src1;
            slot_src2    <= dec_src2;
            slot_use_imm <= dec_use_imm;
            slot_imm     <= dec_imm;
        end else if (issue) begin
            slot_valid <= 1'b0;
        end
    end

    // Output register: data fields only move on issue, valid drops when
    // execute takes the instruction and nothing replaces it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_op        <= '0;
            ex_dst       <= '0;
            ex_we        <= 1'b0;
            ex_opA       <= '0;
            ex_opB       <= '0;
            ex_src2_data <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid     <= 1'b1;
            ex_pc        <= slot_pc;
            ex_op        <= slot_op;
            ex_dst       <= slot_dst;
            ex_we        <= slot_we;
            ex_opA       <= res1;
            ex_opB       <= res_opb;
            ex_src2_data <= res2;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_cycle && (stall_cnt != {CNT_BITS{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_BITS'(1);
        end
    end

endmodule
